// File: rtl/te_rf_pkg.sv
// Shared types and helpers for the te_regfile_mp multi-port register file.
package te_rf_pkg;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_e;

    localparam int XLEN_DEF  = 64;
    localparam int NREGS_DEF = 32;

    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic in_range(input int unsigned addr, input int unsigned n);
        return addr < n;
    endfunction

endpackage

// File: rtl/te_rf_scoreboard.sv
// Per-register busy bits for issue-stage hazard checks: writes clear, allocation sets,
// allocation wins when both hit the same register in one cycle.
module te_rf_scoreboard
    import te_rf_pkg::*;
#(
    parameter int NREGS    = NREGS_DEF,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    parameter int AW       = addr_w(NREGS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear,
    input  logic              allocEn,
    input  logic [AW-1:0]     allocAddr,
    input  logic [NWR-1:0]    wEn,
    input  logic [NWR*AW-1:0] wAddr,
    input  logic [NRD*AW-1:0] rAddr,
    output logic [NRD-1:0]    rBusy
);

    logic [NREGS-1:0] busy;
    logic             alloc_ok;

    assign alloc_ok = allocEn && in_range(32'(allocAddr), NREGS)
                      && !((ZERO_REG != 0) && (allocAddr == '0));

    always_ff @(posedge clk_i) begin
        if (rst_i || clear) begin
            busy <= '0;
        end else begin
            for (int k = 0; k < NWR; k++) begin
                if (wEn[k] && in_range(32'(wAddr[k*AW +: AW]), NREGS))
                    busy[wAddr[k*AW +: AW]] <= 1'b0;
            end
            // Placed after the clears so a same-cycle allocation leaves the bit set.
            if (alloc_ok)
                busy[allocAddr] <= 1'b1;
        end
    end

    always_comb begin
        rBusy = '0;
        for (int j = 0; j < NRD; j++) begin
            if (in_range(32'(rAddr[j*AW +: AW]), NREGS))
                rBusy[j] = busy[rAddr[j*AW +: AW]];
        end
    end

endmodule

// File: rtl/te_regfile_mp.sv
// Multi-port RV64 integer register file with busy scoreboard, post-reset clear FSM and
// operand-B immediate select. Define TE_REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module te_regfile_mp
    import te_rf_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = addr_w(NREGS)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    output logic                ready_o,
    input  logic [NWR-1:0]      wEn_i,
    input  logic [NWR*AW-1:0]   wAddr_i,
    input  logic [NWR*XLEN-1:0] wData_i,
    input  logic [NRD*AW-1:0]   rAddr_i,
    output logic [NRD*XLEN-1:0] rData_o,
    output logic [NRD-1:0]      rBusy_o,
    input  logic                allocEn_i,
    input  logic [AW-1:0]       allocAddr_i,
    input  logic                selImm_i,
    input  logic [XLEN-1:0]     imm_i,
    output logic [XLEN-1:0]     op_b_o
);

    rf_state_e       state, state_nxt;
    logic [AW-1:0]   clr_cnt;
    logic            ready, clearing;
    logic [NWR-1:0]  wen_g;
    logic            alloc_g;
    logic [NRD-1:0]  sb_busy;

    // NOTE: no reset term on the array; the clear FSM zeroes one entry per cycle instead,
    // which keeps the storage mappable onto plain RAM.
    logic [XLEN-1:0] mem [NREGS];

    // Address holds real storage: in range and not the hard-wired zero register.
    function automatic logic live(input logic [AW-1:0] a);
        return in_range(32'(a), NREGS) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= RF_CLEAR;
            clr_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (clearing)
                clr_cnt <= clr_cnt + 1'b1;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            RF_CLEAR: if (clr_cnt == AW'(NREGS - 1)) state_nxt = RF_READY;
            RF_READY: state_nxt = RF_READY;
            default:  state_nxt = RF_CLEAR;
        endcase
    end

    always_comb begin
        ready    = (state == RF_READY);
        clearing = (state == RF_CLEAR);
        wen_g    = (ready && !rst_i) ? wEn_i : '0;
        alloc_g  = ready && !rst_i && allocEn_i;
    end

    assign ready_o = ready;

    // Later loop iterations overwrite earlier ones, so the highest write port wins.
    always_ff @(posedge clk_i) begin
        if (!rst_i && clearing) begin
            mem[clr_cnt] <= '0;
        end else begin
            for (int k = 0; k < NWR; k++) begin
                if (wen_g[k] && live(wAddr_i[k*AW +: AW]))
                    mem[wAddr_i[k*AW +: AW]] <= wData_i[k*XLEN +: XLEN];
            end
        end
    end

    te_rf_scoreboard #(
        .NREGS    (NREGS),
        .NRD      (NRD),
        .NWR      (NWR),
        .ZERO_REG (ZERO_REG),
        .AW       (AW)
    ) u_scoreboard (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear     (clearing),
        .allocEn   (alloc_g),
        .allocAddr (allocAddr_i),
        .wEn       (wen_g),
        .wAddr     (wAddr_i),
        .rAddr     (rAddr_i),
        .rBusy     (sb_busy)
    );

    always_comb begin
        rData_o = '0;
        rBusy_o = '0;
        if (ready) begin
            for (int j = 0; j < NRD; j++) begin
                if (live(rAddr_i[j*AW +: AW]))
                    rData_o[j*XLEN +: XLEN] = mem[rAddr_i[j*AW +: AW]];
                rBusy_o[j] = sb_busy[j];
`ifdef TE_REGFILE_BYPASS_EN
                for (int k = 0; k < NWR; k++) begin
                    if (wen_g[k] && live(wAddr_i[k*AW +: AW])
                        && (wAddr_i[k*AW +: AW] == rAddr_i[j*AW +: AW])) begin
                        rData_o[j*XLEN +: XLEN] = wData_i[k*XLEN +: XLEN];
                        rBusy_o[j]              = 1'b0;
                    end
                end
`endif
            end
        end
    end

    assign op_b_o = ready ? (selImm_i ? imm_i : rData_o[XLEN +: XLEN]) : '0;

endmodule

// File: tb/tb_te_regfile_mp.sv
// Self-checking bench for te_regfile_mp (default parameters); expectations follow TE_REGFILE_BYPASS_EN.
module tb_te_regfile_mp;

    localparam int XLEN = 64;
    localparam int AW   = 5;
`ifdef TE_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic              ready_o;
    logic [1:0]        wEn_i = '0;
    logic [2*AW-1:0]   wAddr_i = '0;
    logic [2*XLEN-1:0] wData_i = '0;
    logic [2*AW-1:0]   rAddr_i = '0;
    logic [2*XLEN-1:0] rData_o;
    logic [1:0]        rBusy_o;
    logic              allocEn_i = 1'b0;
    logic [AW-1:0]     allocAddr_i = '0;
    logic              selImm_i = 1'b0;
    logic [XLEN-1:0]   imm_i = '0;
    logic [XLEN-1:0]   op_b_o;
    logic [XLEN-1:0]   rd0, rd1;

    typedef struct {
        string       name;
        logic [63:0] val;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    int   n_vec = 0;
    int   n_err = 0;

    assign rd0 = rData_o[XLEN-1:0];
    assign rd1 = rData_o[2*XLEN-1:XLEN];

    always #5 clk = ~clk;

    te_regfile_mp dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .ready_o     (ready_o),
        .wEn_i       (wEn_i),
        .wAddr_i     (wAddr_i),
        .wData_i     (wData_i),
        .rAddr_i     (rAddr_i),
        .rData_o     (rData_o),
        .rBusy_o     (rBusy_o),
        .allocEn_i   (allocEn_i),
        .allocAddr_i (allocAddr_i),
        .selImm_i    (selImm_i),
        .imm_i       (imm_i),
        .op_b_o      (op_b_o)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        wEn_i     = '0;
        allocEn_i = 1'b0;
        selImm_i  = 1'b0;
    endtask

    task automatic wr(input int port, input logic [AW-1:0] a, input logic [63:0] d);
        wEn_i[port]                 = 1'b1;
        wAddr_i[port*AW +: AW]      = a;
        wData_i[port*XLEN +: XLEN]  = d;
    endtask

    task automatic rd_addr(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rAddr_i = {a1, a0};
    endtask

    // Counts edges after reset release until ready_o rises (bounded).
    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (cnt < 100 && ready_o !== 1'b1) begin
            tick();
            cnt++;
        end
    endtask

    task automatic test_reset;
        int cnt;
        logic [63:0] or_data;
        logic        or_busy;
        rst_i = 1'b1;
        idle();
        repeat (3) tick();
        sb_q.push_back('{name:"reset_ready_low", val:64'd0});
        e = sb_q.pop_front(); n_vec++;
        if (64'(ready_o) !== e.val) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, ready_o, e.val); end

        rst_i = 1'b0;
        cnt = 0;
        while (cnt < 100 && ready_o !== 1'b1) begin
            idle();
            if (cnt == 3) begin
                // Outputs held at zero while clearing, even with an immediate selected.
                selImm_i = 1'b1;
                imm_i    = 64'hFF;
                rd_addr(5'd0, 5'd1);
                #1;
                sb_q.push_back('{name:"clear_op_b_zero", val:64'd0});
                sb_q.push_back('{name:"clear_rdata_zero", val:64'd0});
                e = sb_q.pop_front(); n_vec++;
                if (op_b_o !== e.val) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, op_b_o, e.val); end
                e = sb_q.pop_front(); n_vec++;
                if ((rd0 | rd1) !== e.val) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, rd0 | rd1, e.val); end
            end
            if (cnt == 5) begin
                // Write to an already-cleared entry and an allocation; both must be ignored.
                wr(0, 5'd1, 64'h55);
                allocEn_i   = 1'b1;
                allocAddr_i = 5'd2;
            end
            tick();
            cnt++;
        end
        idle();
        sb_q.push_back('{name:"reset_ready_cycles", val:64'd32});
        e = sb_q.pop_front(); n_vec++;
        if (64'(cnt) !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, cnt, e.val); end

        or_data = '0;
        or_busy = 1'b0;
        for (int r = 0; r < 32; r++) begin
            rd_addr(AW'(r), AW'(r));
            #1;
            or_data = or_data | rd0 | rd1;
            or_busy = or_busy | rBusy_o[0] | rBusy_o[1];
        end
        sb_q.push_back('{name:"post_clear_all_zero", val:64'd0});
        sb_q.push_back('{name:"post_clear_no_busy", val:64'd0});
        e = sb_q.pop_front(); n_vec++;
        if (or_data !== e.val) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, or_data, e.val); end
        e = sb_q.pop_front(); n_vec++;
        if (64'(or_busy) !== e.val) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, or_busy, e.val); end
    endtask

    task automatic test_write_conflict;
        wr(0, 5'd5, 64'hAA);
        wr(1, 5'd5, 64'hBB);
        sb_q.push_back('{name:"conflict_r5", val:64'hBB});
        tick();
        idle();
        rd_addr(5'd5, 5'd0);
        #1;
        e = sb_q.pop_front(); n_vec++;
        if (rd0 !== e.val) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, rd0, e.val); end

        wr(0, 5'd8, 64'h88);
        wr(1, 5'd9, 64'h99);
        sb_q.push_back('{name:"dual_write_r8", val:64'h88});
        sb_q.push_back('{name:"dual_write_r9", val:64'h99});
        tick();
        idle();
        rd_addr(5'd8, 5'd9);
        #1;
        e = sb_q.pop_front(); n_vec++;
        if (rd0 !== e.val) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, rd0, e.val); end
        e = sb_q.pop_front(); n_vec++;
        if (rd1 !== e.val) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, rd1, e.val); end
    endtask

    task automatic test_zero_reg;
        wr(0, 5'd0, 64'hFFFF);
        allocEn_i   = 1'b1;
        allocAddr_i = 5'd0;
        sb_q.push_back('{name:"r0_data", val:64'd0});
        sb_q.push_back('{name:"r0_busy", val:64'd0});
        tick();
        idle();
        rd_addr(5'd0, 5'd0);
        #1;
        e = sb_q.pop_front(); n_vec++;
        if (rd0 !== e.val) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, rd0, e.val); end
        e = sb_q.pop_front(); n_vec++;
        if (64'(rBusy_o[0]) !== e.val) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, rBusy_o[0], e.val); end
    endtask

    task automatic test_alloc_write;
        wr(0, 5'd7, 64'h11);
        allocEn_i   = 1'b1;
        allocAddr_i = 5'd7;
        sb_q.push_back('{name:"alloc_wins_busy", val:64'd1});
        sb_q.push_back('{name:"alloc_write_data", val:64'h11});
        tick();
        idle();
        rd_addr(5'd7, 5'd0);
        #1;
        e = sb_q.pop_front(); n_vec++;
        if (64'(rBusy_o[0]) !== e.val) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, rBusy_o[0], e.val); end
        e = sb_q.pop_front(); n_vec++;
        if (rd0 !== e.val) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, rd0, e.val); end

        wr(1, 5'd7, 64'h22);
        sb_q.push_back('{name:"write_clears_busy", val:64'd0});
        sb_q.push_back('{name:"write_only_data", val:64'h22});
        tick();
        idle();
        #1;
        e = sb_q.pop_front(); n_vec++;
        if (64'(rBusy_o[0]) !== e.val) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, rBusy_o[0], e.val); end
        e = sb_q.pop_front(); n_vec++;
        if (rd0 !== e.val) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, rd0, e.val); end
    endtask

    task automatic test_bypass;
        rd_addr(5'd3, 5'd0);
        wr(0, 5'd3, 64'h1234);
        sb_q.push_back('{name:"bypass_same_cycle", val:(BYP ? 64'h1234 : 64'd0)});
        #1;
        e = sb_q.pop_front(); n_vec++;
        if (rd0 !== e.val) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, rd0, e.val); end
        sb_q.push_back('{name:"bypass_next_cycle", val:64'h1234});
        tick();
        idle();
        #1;
        e = sb_q.pop_front(); n_vec++;
        if (rd0 !== e.val) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, rd0, e.val); end

        allocEn_i   = 1'b1;
        allocAddr_i = 5'd12;
        tick();
        idle();
        rd_addr(5'd13, 5'd12);
        wr(1, 5'd12, 64'hC0DE);
        sb_q.push_back('{name:"bypass_busy", val:(BYP ? 64'd0 : 64'd1)});
        sb_q.push_back('{name:"bypass_port1_data", val:(BYP ? 64'hC0DE : 64'd0)});
        #1;
        e = sb_q.pop_front(); n_vec++;
        if (64'(rBusy_o[1]) !== e.val) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, rBusy_o[1], e.val); end
        e = sb_q.pop_front(); n_vec++;
        if (rd1 !== e.val) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, rd1, e.val); end
        tick();
        idle();

        wr(0, 5'd13, 64'hA);
        wr(1, 5'd13, 64'hB);
        sb_q.push_back('{name:"bypass_high_port", val:(BYP ? 64'hB : 64'd0)});
        #1;
        e = sb_q.pop_front(); n_vec++;
        if (rd0 !== e.val) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, rd0, e.val); end
        tick();
        idle();
    endtask

    task automatic test_op_b;
        rd_addr(5'd0, 5'd3);
        imm_i    = 64'h7F;
        selImm_i = 1'b1;
        sb_q.push_back('{name:"op_b_imm", val:64'h7F});
        #1;
        e = sb_q.pop_front(); n_vec++;
        if (op_b_o !== e.val) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, op_b_o, e.val); end
        selImm_i = 1'b0;
        sb_q.push_back('{name:"op_b_reg", val:64'h1234});
        #1;
        e = sb_q.pop_front(); n_vec++;
        if (op_b_o !== e.val) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, op_b_o, e.val); end
    endtask

    task automatic test_reset_mid_clear;
        int cnt;
        idle();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        repeat (10) tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        sb_q.push_back('{name:"restart_ready_cycles", val:64'd32});
        wait_ready(cnt);
        e = sb_q.pop_front(); n_vec++;
        if (64'(cnt) !== e.val) begin n_err++; $display("FAIL %s: got %0d want %0d", e.name, cnt, e.val); end
        rd_addr(5'd3, 5'd7);
        sb_q.push_back('{name:"restart_r3_cleared", val:64'd0});
        sb_q.push_back('{name:"restart_r7_cleared", val:64'd0});
        #1;
        e = sb_q.pop_front(); n_vec++;
        if (rd0 !== e.val) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, rd0, e.val); end
        e = sb_q.pop_front(); n_vec++;
        if (rd1 !== e.val) begin n_err++; $display("FAIL %s: got %0h want %0h", e.name, rd1, e.val); end
    endtask

    initial begin
        test_reset();
        test_write_conflict();
        test_zero_reg();
        test_alloc_write();
        test_bypass();
        test_op_b();
        test_reset_mid_clear();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
